// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one single-port sprite ROM (registered 1-cycle read on vga_clk) among NUM_REQ
//   requesters: the background mapper, the Pac-Man sprite and the ghost sprites.
//   Round-robin arbitration with a registered one-hot grant, a ROM address mux and a two-stage
//   tag pipeline (issue -> return) that delivers each read's data with the owner's ID.
//
// Ports
//   vga_clk      sole clock; the ROM is clocked on the same edge
//   reset        asynchronous, active-high reset
//   arb_en       when low no new grants are issued; in-flight reads still complete
//   req          per-requester level request
//   req_addr     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt          one-hot grant, one-cycle pulse
//   rom_address  to the ROM address port
//   rom_q        from the ROM, valid one cycle after rom_address is registered
//   rd_valid     rd_data/rd_id valid this cycle
//   rd_id        requester that owns rd_data
//   rd_data      rom_q passed straight through
//   busy         a read is in the issue or return stage
//
// Build option
//   SPRITE_ARB_PRIO0_EN  requester 0 gets strict priority; round-robin among the others only.

module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 3,
    parameter int unsigned ID_W    = 2
) (
    input  logic                       vga_clk,
    input  logic                       reset,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [ADDR_W-1:0]          rom_address,
    input  logic [DATA_W-1:0]          rom_q,
    output logic                       rd_valid,
    output logic [ID_W-1:0]            rd_id,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy
);

    logic [ID_W-1:0]    ptr_q;
    logic               issue_valid_q;
    logic [ID_W-1:0]    issue_id_q;

    logic [NUM_REQ-1:0] eligible;
    logic               rr_found;
    logic [ID_W-1:0]    rr_id;
    int unsigned        idx;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic               ptr_upd;
    logic [ID_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [ADDR_W-1:0]  addr_next;

    // Round-robin search from ptr upward. ptr is always < NUM_REQ, so a single subtraction
    // wraps the index and indices >= NUM_REQ are never visited.
    always_comb begin
        // Last cycle's grantee is masked so it has one cycle to drop req.
        eligible = req & ~gnt;
        rr_found = 1'b0;
        rr_id    = '0;
        idx      = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!rr_found && eligible[idx]) begin
                rr_found = 1'b1;
                rr_id    = ID_W'(idx);
            end
        end
    end

`ifdef SPRITE_ARB_PRIO0_EN
    // Background mapper wins whenever eligible and leaves ptr alone; when it is not eligible
    // the search above skips index 0 by itself.
    assign win_found = eligible[0] | rr_found;
    assign win_id    = eligible[0] ? '0 : rr_id;
    assign ptr_upd   = rr_found & ~eligible[0];
`else
    assign win_found = rr_found;
    assign win_id    = rr_id;
    assign ptr_upd   = rr_found;
`endif

    always_comb begin
        gnt_next         = '0;
        gnt_next[win_id] = 1'b1;
        ptr_next         = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        addr_next        = req_addr[32'(win_id) * ADDR_W +: ADDR_W];
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            gnt           <= '0;
            rom_address   <= '0;
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_id_q    <= '0;
            rd_valid      <= 1'b0;
            rd_id         <= '0;
        end else begin
            // Return stage lines up with the ROM registering q on this same edge.
            rd_valid <= issue_valid_q;
            rd_id    <= issue_id_q;
            if (arb_en && win_found) begin
                gnt           <= gnt_next;
                rom_address   <= addr_next;
                issue_valid_q <= 1'b1;
                issue_id_q    <= win_id;
                if (ptr_upd) begin
                    ptr_q <= ptr_next;
                end
            end else begin
                gnt           <= '0;
                issue_valid_q <= 1'b0;
            end
        end
    end

    assign rd_data = rom_q;
    assign busy    = issue_valid_q | rd_valid;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Testbench for sprite_rom_arbiter (NUM_REQ=4, ADDR_W=9, DATA_W=3, ID_W=2) with a registered
// ROM model whose contents are rom[a] = a[2:0] ^ 3'b110.

module tb_sprite_rom_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        arb_en;
    logic [3:0]  req;
    logic [35:0] req_addr;
    logic [3:0]  gnt;
    logic [8:0]  rom_address;
    logic [2:0]  rom_q;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [2:0]  rd_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (9),
        .DATA_W  (3),
        .ID_W    (2)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .arb_en      (arb_en),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rd_valid    (rd_valid),
        .rd_id       (rd_id),
        .rd_data     (rd_data),
        .busy        (busy)
    );

    function automatic logic [2:0] rom_fn(input logic [8:0] a);
        return a[2:0] ^ 3'b110;
    endfunction

    always_ff @(posedge vga_clk) rom_q <= rom_fn(rom_address);

    typedef struct packed {
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [8:0] addr;
        logic       rv;
        logic [1:0] id;
        logic [2:0] data;
        logic       busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        arb_en = 1'b0;
        req    = 4'b0000;
        step();
        step();
        reset  = 1'b0;
    endtask

    initial begin
        vec_t vecs[21];
        // addresses: r0=015 (rom 3), r1=0A2 (rom 4), r2=133 (rom 5), r3=1F4 (rom 2)
        req_addr = {9'h1F4, 9'h133, 9'h0A2, 9'h015};

        do_reset();
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_rom_address", 32'(rom_address), 32'h0);
        check("reset_rd_valid", 32'(rd_valid), 32'h0);
        check("reset_rd_id", 32'(rd_id), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

`ifndef SPRITE_ARB_PRIO0_EN
        //            en    req      gnt      addr    rv    id    data  busy
        vecs[0]  = '{1'b1, 4'b0001, 4'b0001, 9'h015, 1'b0, 2'd0, 3'd0, 1'b1};
        vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 9'h015, 1'b1, 2'd0, 3'd3, 1'b1};
        vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 9'h015, 1'b0, 2'd0, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 4'b1111, 4'b0010, 9'h0A2, 1'b0, 2'd0, 3'd0, 1'b1};
        vecs[4]  = '{1'b1, 4'b1111, 4'b0100, 9'h133, 1'b1, 2'd1, 3'd4, 1'b1};
        vecs[5]  = '{1'b1, 4'b1111, 4'b1000, 9'h1F4, 1'b1, 2'd2, 3'd5, 1'b1};
        vecs[6]  = '{1'b1, 4'b1111, 4'b0001, 9'h015, 1'b1, 2'd3, 3'd2, 1'b1};
        vecs[7]  = '{1'b1, 4'b1111, 4'b0010, 9'h0A2, 1'b1, 2'd0, 3'd3, 1'b1};
        vecs[8]  = '{1'b1, 4'b0100, 4'b0100, 9'h133, 1'b1, 2'd1, 3'd4, 1'b1};
        vecs[9]  = '{1'b1, 4'b0100, 4'b0000, 9'h133, 1'b1, 2'd2, 3'd5, 1'b1};
        vecs[10] = '{1'b1, 4'b0100, 4'b0100, 9'h133, 1'b0, 2'd0, 3'd0, 1'b1};
        vecs[11] = '{1'b1, 4'b0100, 4'b0000, 9'h133, 1'b1, 2'd2, 3'd5, 1'b1};
        vecs[12] = '{1'b1, 4'b0000, 4'b0000, 9'h133, 1'b0, 2'd0, 3'd0, 1'b0};
        vecs[13] = '{1'b1, 4'b0010, 4'b0010, 9'h0A2, 1'b0, 2'd0, 3'd0, 1'b1};
        vecs[14] = '{1'b0, 4'b1111, 4'b0000, 9'h0A2, 1'b1, 2'd1, 3'd4, 1'b1};
        vecs[15] = '{1'b0, 4'b1111, 4'b0000, 9'h0A2, 1'b0, 2'd0, 3'd0, 1'b0};
        vecs[16] = '{1'b1, 4'b1111, 4'b0100, 9'h133, 1'b0, 2'd0, 3'd0, 1'b1};
        vecs[17] = '{1'b1, 4'b0000, 4'b0000, 9'h133, 1'b1, 2'd2, 3'd5, 1'b1};
        vecs[18] = '{1'b1, 4'b0000, 4'b0000, 9'h133, 1'b0, 2'd0, 3'd0, 1'b0};
        vecs[19] = '{1'b0, 4'b1000, 4'b0000, 9'h133, 1'b0, 2'd0, 3'd0, 1'b0};
        vecs[20] = '{1'b1, 4'b0000, 4'b0000, 9'h133, 1'b0, 2'd0, 3'd0, 1'b0};

        for (int i = 0; i < 21; i++) begin
            arb_en = vecs[i].en;
            req    = vecs[i].req;
            step();
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_rom_address", i), 32'(rom_address), 32'(vecs[i].addr));
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            if (vecs[i].rv) begin
                check($sformatf("vec%0d_rd_id", i), 32'(rd_id), 32'(vecs[i].id));
                check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].data));
            end
        end
`else
        begin
            // req=1011 held from ptr=0: 0 wins every eligible cycle, 1 and 3 share the slots.
            logic [3:0] exp_gnt[8];
            logic [1:0] exp_id[8];
            exp_gnt = '{4'b0001, 4'b0010, 4'b0001, 4'b1000, 4'b0001, 4'b0010, 4'b0001, 4'b1000};
            exp_id  = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3};
            arb_en = 1'b1;
            req    = 4'b1011;
            for (int k = 0; k < 8; k++) begin
                step();
                check($sformatf("prio_gnt%0d", k), 32'(gnt), 32'(exp_gnt[k]));
                if (k > 0) begin
                    check($sformatf("prio_rd_valid%0d", k), 32'(rd_valid), 32'h1);
                    check($sformatf("prio_rd_id%0d", k), 32'(rd_id), 32'(exp_id[k-1]));
                end
            end
            req = 4'b0000;
            step();
            step();
        end
`endif

        // Reset while a read is in the issue stage: it must never return.
        do_reset();
        arb_en = 1'b1;
        req    = 4'b0001;
        step();
        check("mid_gnt_before", 32'(gnt), 32'h1);
        check("mid_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_async_gnt", 32'(gnt), 32'h0);
        check("mid_async_busy", 32'(busy), 32'h0);
        check("mid_async_rom_address", 32'(rom_address), 32'h0);
        req = 4'b0000;
        step();
        reset = 1'b0;
        step();
        check("mid_rd_valid_a", 32'(rd_valid), 32'h0);
        step();
        check("mid_rd_valid_b", 32'(rd_valid), 32'h0);
        // ptr was 1 before reset; a reset ptr grants requester 0 first.
        req = 4'b1111;
        step();
        check("mid_ptr_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        check("mid_ret_rd_valid", 32'(rd_valid), 32'h1);
        check("mid_ret_rd_id", 32'(rd_id), 32'h0);
        check("mid_ret_rd_data", 32'(rd_data), 32'h3);
        step();
        check("mid_idle_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
